// File: rtl/photon_count_controller.sv
// photon_count_controller
// Decodes opcode/argument command words from the SPI receive path and
// sequences a programmable counting gate across the photon counter bank,
// plus per-channel readout requests with an acknowledge handshake.
module photon_count_controller #(
  parameter int CMD_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 4,
  parameter int GATE_WIDTH   = 24,
  parameter int GATE_DEFAULT = 1000,
  parameter int N_CHANNELS   = 4,
  parameter int CH_SEL_WIDTH = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [CMD_WIDTH-1:0]    RX,
  input  logic                    RX_VALID,
  input  logic                    READ_ACK,
  output logic                    COUNT_CLR,
  output logic                    COUNT_EN,
  output logic                    END_COUNT,
  output logic                    READ_DATA,
  output logic [CH_SEL_WIDTH-1:0] READ_CH,
  output logic                    BUSY,
  output logic                    CMD_ERR
);

  localparam int ARG_W = CMD_WIDTH - OPCODE_WIDTH;
  localparam int HI_W  = GATE_WIDTH - ARG_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_COUNTING = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_READOUT  = 3'd4;

  localparam logic [OPCODE_WIDTH-1:0] OP_ABORT   = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_START   = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SET_LO  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SET_HI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_READ    = OPCODE_WIDTH'(4);

  logic [2:0]              r_state;
  logic [GATE_WIDTH-1:0]   r_gate;
  logic [GATE_WIDTH-1:0]   r_timer;
  logic [CH_SEL_WIDTH-1:0] r_ch;
  logic                    r_count_clr;
  logic                    r_count_en;
  logic                    r_end_count;
  logic                    r_read_data;
  logic                    r_busy;
  logic                    r_cmd_err;

  logic [OPCODE_WIDTH-1:0] w_op;
  logic [ARG_W-1:0]        w_arg;
  logic                    w_abort;
  logic                    w_other;
  logic                    w_ch_ok;
  logic [2:0]              w_ns;
  logic                    w_err;
  logic                    w_gate_lo_we;
  logic                    w_gate_hi_we;
  logic                    w_ch_we;

  assign w_op    = RX[CMD_WIDTH-1 -: OPCODE_WIDTH];
  assign w_arg   = RX[ARG_W-1:0];
  assign w_abort = RX_VALID && (w_op == OP_ABORT);
  assign w_other = RX_VALID && (w_op != OP_ABORT);
  // Channel range is judged on the whole argument, not just the select bits
  assign w_ch_ok = (w_arg < ARG_W'(N_CHANNELS));

  // Next-state and command decode
  always_comb begin
    w_ns         = r_state;
    w_err        = 1'b0;
    w_gate_lo_we = 1'b0;
    w_gate_hi_we = 1'b0;
    w_ch_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (RX_VALID) begin
          case (w_op)
            OP_ABORT:  ;
            OP_START:  if (r_gate == '0) w_err = 1'b1; else w_ns = S_CLEAR;
            OP_SET_LO: w_gate_lo_we = 1'b1;
            OP_SET_HI: w_gate_hi_we = 1'b1;
            OP_READ: begin
              if (w_ch_ok) begin
                w_ch_we = 1'b1;
                w_ns    = S_READOUT;
              end else begin
                w_err = 1'b1;
              end
            end
            default:   w_err = 1'b1;
          endcase
        end
      end
      S_CLEAR: begin
        w_err = w_other;
        w_ns  = w_abort ? S_IDLE : S_COUNTING;
      end
      S_COUNTING: begin
        // Abort takes priority over a coincident expiry: no END_COUNT
        if (w_abort) begin
          w_ns = S_IDLE;
        end else begin
          w_err = w_other;
          if (r_timer == GATE_WIDTH'(1)) w_ns = S_DONE;
        end
      end
      S_DONE: begin
        w_err = w_other;
        w_ns  = S_IDLE;
      end
      S_READOUT: begin
        w_err = w_other;
        if (w_abort || READ_ACK) w_ns = S_IDLE;
      end
      default: w_ns = S_IDLE;
    endcase
  end

  // State, gate register, timer and channel latch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_gate  <= GATE_WIDTH'(GATE_DEFAULT);
      r_timer <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_ns;
      if (w_gate_lo_we) r_gate[ARG_W-1:0] <= w_arg;
      if (w_gate_hi_we) r_gate[GATE_WIDTH-1:ARG_W] <= w_arg[HI_W-1:0];
      if (r_state == S_CLEAR) r_timer <= r_gate;
      else if (r_state == S_COUNTING) r_timer <= r_timer - GATE_WIDTH'(1);
      if (w_ch_we) r_ch <= w_arg[CH_SEL_WIDTH-1:0];
    end
  end

  // Outputs registered from the next state so each lines up with its state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count_clr <= 1'b0;
      r_count_en  <= 1'b0;
      r_end_count <= 1'b0;
      r_read_data <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_count_clr <= (w_ns == S_CLEAR);
      r_count_en  <= (w_ns == S_COUNTING);
      r_end_count <= (w_ns == S_DONE);
      r_read_data <= (w_ns == S_READOUT);
      r_busy      <= (w_ns != S_IDLE);
      r_cmd_err   <= w_err;
    end
  end

  assign COUNT_CLR = r_count_clr;
  assign COUNT_EN  = r_count_en;
  assign END_COUNT = r_end_count;
  assign READ_DATA = r_read_data;
  assign READ_CH   = r_ch;
  assign BUSY      = r_busy;
  assign CMD_ERR   = r_cmd_err;

endmodule

// File: tb/tb_photon_count_controller.sv
// Self-checking bench for photon_count_controller: cycle-by-cycle expected
// output words go through a scoreboard queue and are compared after each edge.
module tb_photon_count_controller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] RX;
  logic        RX_VALID;
  logic        READ_ACK;
  logic        COUNT_CLR, COUNT_EN, END_COUNT, READ_DATA, BUSY, CMD_ERR;
  logic [1:0]  READ_CH;
  logic [7:0]  dut_o;

  int checks = 0;
  int errors = 0;
  logic [1:0] m_ch;

  typedef struct {
    logic [7:0] val;
    string      tag;
  } exp_t;

  typedef struct {
    logic        v;
    logic [15:0] rx;
    logic        ack;
    logic [7:0]  exp;
    string       tag;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  photon_count_controller #(
    .CMD_WIDTH(16), .OPCODE_WIDTH(4), .GATE_WIDTH(24),
    .GATE_DEFAULT(1000), .N_CHANNELS(4), .CH_SEL_WIDTH(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .RX(RX), .RX_VALID(RX_VALID),
    .READ_ACK(READ_ACK), .COUNT_CLR(COUNT_CLR), .COUNT_EN(COUNT_EN),
    .END_COUNT(END_COUNT), .READ_DATA(READ_DATA), .READ_CH(READ_CH),
    .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // {clr, en, end, rd, busy, err, ch[1:0]}
  assign dut_o = {COUNT_CLR, COUNT_EN, END_COUNT, READ_DATA, BUSY, CMD_ERR, READ_CH};

  function automatic logic [7:0] o(bit clr, bit en, bit e, bit rd, bit busy,
                                   bit err, logic [1:0] ch);
    return {clr, en, e, rd, busy, err, ch};
  endfunction

  function automatic logic [7:0] e_idle();   return o(0,0,0,0,0,0,m_ch); endfunction
  function automatic logic [7:0] e_err();    return o(0,0,0,0,0,1,m_ch); endfunction
  function automatic logic [7:0] e_clr();    return o(1,0,0,0,1,0,m_ch); endfunction
  function automatic logic [7:0] e_en();     return o(0,1,0,0,1,0,m_ch); endfunction
  function automatic logic [7:0] e_en_err(); return o(0,1,0,0,1,1,m_ch); endfunction
  function automatic logic [7:0] e_end();    return o(0,0,1,0,1,0,m_ch); endfunction
  function automatic logic [7:0] e_rd();     return o(0,0,0,1,1,0,m_ch); endfunction

  task automatic drive(input logic v, input logic [15:0] rx, input logic ack);
    RX_VALID = v;
    RX       = rx;
    READ_ACK = ack;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (clr,en,end,rd,busy,err,ch)", tag, got, exp);
    end
  endtask

  // Push the expectation for the cycle after the next edge, then sample it
  task automatic cyc(input logic [7:0] e, input string tag);
    exp_t x;
    x.val = e;
    x.tag = tag;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    drive(1'b0, 16'h0000, 1'b0);
    x = sb.pop_front();
    chk(x.tag, dut_o, x.val);
  endtask

  task automatic run_gate(input int g, input string tag);
    drive(1'b1, 16'h1000, 1'b0);
    cyc(e_clr(), {tag, "_clr"});
    repeat (g) cyc(e_en(), {tag, "_en"});
    cyc(e_end(), {tag, "_end"});
    cyc(e_idle(), {tag, "_idle"});
  endtask

  task automatic set_gate(input logic [11:0] lo, input logic [11:0] hi);
    drive(1'b1, {4'h2, lo}, 1'b0);
    cyc(e_idle(), "set_gate_lo");
    drive(1'b1, {4'h3, hi}, 1'b0);
    cyc(e_idle(), "set_gate_hi");
  endtask

  task automatic add(input logic v, input logic [15:0] rx, input logic ack,
                     input logic [7:0] exp, input string tag);
    vec_t t;
    t.v = v; t.rx = rx; t.ack = ack; t.exp = exp; t.tag = tag;
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    m_ch  = 2'd0;
    drive(1'b0, 16'h0000, 1'b0);

    // Command sequence applied one vector per cycle after the async-reset test
    add(1, 16'h2007, 0, o(0,0,0,0,0,0,2'd0), "tbl_setlo7");
    add(1, 16'h3000, 0, o(0,0,0,0,0,0,2'd0), "tbl_sethi0");
    add(1, 16'hF000, 0, o(0,0,0,0,0,1,2'd0), "tbl_illegal_F");
    add(0, 16'h0000, 0, o(0,0,0,0,0,0,2'd0), "tbl_quiet");
    add(1, 16'h9ABC, 0, o(0,0,0,0,0,1,2'd0), "tbl_illegal_9");
    add(1, 16'h0000, 0, o(0,0,0,0,0,0,2'd0), "tbl_abort_idle");
    add(0, 16'h0000, 1, o(0,0,0,0,0,0,2'd0), "tbl_ack_idle");
    add(1, 16'h4003, 0, o(0,0,0,1,1,0,2'd3), "tbl_read3");
    add(0, 16'h0000, 0, o(0,0,0,1,1,0,2'd3), "tbl_read3_hold");
    add(1, 16'h2003, 1, o(0,0,0,0,0,1,2'd3), "tbl_ack_with_setlo");
    add(1, 16'h4001, 0, o(0,0,0,1,1,0,2'd1), "tbl_read1");
    add(1, 16'h0000, 0, o(0,0,0,0,0,0,2'd1), "tbl_abort_read");
    add(1, 16'h4004, 0, o(0,0,0,0,0,1,2'd1), "tbl_read4_bad");
    add(0, 16'h0000, 0, o(0,0,0,0,0,0,2'd1), "tbl_quiet2");

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", dut_o, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_reset_idle", dut_o, 8'h00);

    // Default gate length
    run_gate(1000, "gate1000");

    // Short gate, then zero gate rejected
    set_gate(12'h005, 12'h000);
    run_gate(5, "gate5");
    set_gate(12'h000, 12'h000);
    drive(1'b1, 16'h1000, 1'b0);
    cyc(e_err(), "start_gate0_err");
    repeat (3) cyc(e_idle(), "gate0_quiet");

    // Gate 100: START mid-gate rejected, ABORT in counting cycle 40
    set_gate(12'h064, 12'h000);
    drive(1'b1, 16'h1000, 1'b0);
    cyc(e_clr(), "g100_clr");
    repeat (10) cyc(e_en(), "g100_en");
    drive(1'b1, 16'h1000, 1'b0);
    cyc(e_en_err(), "g100_start_err");
    repeat (29) cyc(e_en(), "g100_en_cont");
    drive(1'b1, 16'h0000, 1'b0);
    cyc(e_idle(), "g100_abort");
    repeat (3) cyc(e_idle(), "g100_no_end");
    run_gate(100, "g100_rerun");

    // Read channel 2, held for 10 cycles until ACK; out-of-range read
    drive(1'b1, 16'h4002, 1'b0);
    m_ch = 2'd2;
    cyc(e_rd(), "read2");
    repeat (9) cyc(e_rd(), "read2_hold");
    drive(1'b0, 16'h0000, 1'b1);
    cyc(e_idle(), "read2_ack");
    drive(1'b1, 16'h4005, 1'b0);
    cyc(e_err(), "read5_err");
    cyc(e_idle(), "read5_quiet");

    // Asynchronous reset mid-gate
    set_gate(12'h014, 12'h000);
    drive(1'b1, 16'h1000, 1'b0);
    cyc(e_clr(), "rst_gate_clr");
    repeat (5) cyc(e_en(), "rst_gate_en");
    #2;
    RST_N = 1'b0;
    #1;
    m_ch = 2'd0;
    chk("async_reset_drop", dut_o, 8'h00);
    #1;
    RST_N = 1'b1;
    repeat (3) cyc(e_idle(), "post_rst_no_end");
    run_gate(1000, "post_rst_gate1000");

    // Table-driven command vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].rx, tbl[i].ack);
      cyc(tbl[i].exp, tbl[i].tag);
    end
    m_ch = 2'd1;
    run_gate(7, "tbl_gate7_unchanged");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/photon_count_controller.md
Name: photon_count_controller

Overview:
- Parametrised successor to the 16-bit counting controller: decodes opcode/argument command words from the SPI slave and sequences a timed gate across N_CHANNELS photon counters.
- Sits between the SPI receive path and the counter bank/readout mux.
- Adds a programmable gate length, an abort command, per-channel read select with an acknowledge handshake, and error reporting.

Parameters:
- CMD_WIDTH, 16, width of the received command word.
- OPCODE_WIDTH, 4, opcode field in RX[CMD_WIDTH-1 -: OPCODE_WIDTH]; argument ARG = remaining low CMD_WIDTH-OPCODE_WIDTH bits (12 by default).
- GATE_WIDTH, 24, gate-length register width; must be ≤ 2*ARG width.
- GATE_DEFAULT, 1000, gate length in CLK cycles after reset; must be ≥ 1.
- N_CHANNELS, 4, number of counter channels.
- CH_SEL_WIDTH, 2, width of READ_CH; must be ≥ clog2(N_CHANNELS).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RX  in  CMD_WIDTH  command word from the SPI slave.
- RX_VALID  in  1  one-cycle strobe; RX is sampled only when this is high.
- READ_ACK  in  1  readout path has consumed the selected channel.
- COUNT_CLR  out  1  one-cycle clear pulse to all counters.
- COUNT_EN  out  1  counters increment while high.
- END_COUNT  out  1  one-cycle pulse when a gate completes normally.
- READ_DATA  out  1  read request, held until acknowledged.
- READ_CH  out  CH_SEL_WIDTH  selected channel for readout.
- BUSY  out  1  high in every state except IDLE.
- CMD_ERR  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (asynchronous, RST_N low):
  - All outputs 0; state IDLE; timer 0; gate register = GATE_DEFAULT.
  - A reset mid-gate or mid-read drops COUNT_EN and READ_DATA immediately; no END_COUNT is issued.
- All outputs are registered.
- Opcodes:
  - 0x0 ABORT.
  - 0x1 START.
  - 0x2 SET_GATE_LO: gate[11:0] = ARG.
  - 0x3 SET_GATE_HI: gate[GATE_WIDTH-1:12] = ARG, truncated to fit.
  - 0x4 READ: channel = ARG[CH_SEL_WIDTH-1:0].
  - Any other opcode is illegal.
- States: IDLE, CLEAR, COUNTING, DONE, READOUT.
- IDLE:
  - START with gate ≠ 0 → CLEAR.
  - START with gate = 0 → CMD_ERR, stay in IDLE.
  - SET_GATE_* → update the register, stay in IDLE.
  - READ with ARG channel < N_CHANNELS → latch READ_CH, go to READOUT.
  - READ with ARG channel ≥ N_CHANNELS → CMD_ERR, stay in IDLE.
  - ABORT → no-op.
  - Illegal opcode → CMD_ERR.
- CLEAR: COUNT_CLR = 1 for exactly one cycle; load timer = gate; → COUNTING.
- COUNTING:
  - COUNT_EN = 1; timer decrements each cycle; COUNT_EN is high for exactly `gate` cycles.
  - Leaving COUNTING on expiry → DONE.
  - ABORT → COUNT_EN low on the next cycle, go to IDLE, no END_COUNT.
  - Any other command → CMD_ERR; the gate continues unaffected.
- DONE: END_COUNT = 1 for exactly one cycle, in the cycle immediately after COUNT_EN falls; → IDLE.
- READOUT:
  - READ_DATA = 1 and READ_CH stable until READ_ACK is sampled high.
  - On READ_ACK: READ_DATA goes 0 the next cycle; → IDLE.
  - ABORT → IDLE with READ_DATA 0.
  - Any other command → CMD_ERR.
  - READ_ACK and RX_VALID in the same cycle: the ACK is honoured and the command is treated as received in READOUT, i.e. CMD_ERR unless it is ABORT.
- Gate register updates take effect at the next START only; the timer is loaded in CLEAR.
- Latency: START sampled at edge k → COUNT_CLR high in cycle k+1, COUNT_EN high in cycles k+2 .. k+1+G, END_COUNT high in cycle k+2+G.
- READ_ACK outside READOUT is ignored.

Test Plan:
- Reset, then START with the default gate → COUNT_CLR pulse 1 cycle after START, COUNT_EN high exactly 1000 cycles, END_COUNT single pulse the next cycle, BUSY low afterwards.
- SET_GATE_LO 0x005, SET_GATE_HI 0x000, START → COUNT_EN high exactly 5 cycles; SET_GATE_LO 0x000, SET_GATE_HI 0x000, START → CMD_ERR pulse, COUNT_CLR and COUNT_EN never rise.
- Gate = 100, START, ABORT at cycle 40 of counting → COUNT_EN low the next cycle, no END_COUNT, state IDLE; a START issued during counting → CMD_ERR only, gate length unchanged.
- READ 0x4002 → READ_DATA = 1, READ_CH = 2 held for 10 cycles until READ_ACK, READ_DATA 0 the next cycle; READ 0x4005 with N_CHANNELS = 4 → CMD_ERR, READ_DATA stays 0.
- RST_N pulsed low asynchronously mid-gate (between edges) → COUNT_EN drops immediately, gate register returns to 1000, END_COUNT never pulses.
- Illegal opcode 0xF in IDLE → CMD_ERR pulse, no state change; READ_ACK and SET_GATE_LO arriving together in READOUT → READ_DATA falls, CMD_ERR pulses, gate register unchanged.
